// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle for cache_mem_arbiter: I-cache and D-cache miss ports plus the shared memory port.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and D-cache.
// Define ARB_PERF_CNT_EN to add grant and conflict-cycle performance counters.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]        perf_i_grants,
    output logic [15:0]        perf_d_grants,
    output logic [15:0]        perf_conflict_cycles
`endif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e state;
    state_e state_next;
    logic   last_grant;
    logic   last_grant_next;
    logic   i_req;
    logic   d_req;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    // State and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Grant selection; a tie goes to the cache that was not served last
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_next = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end else if (d_req) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I: begin
                if (bus.pmem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = GRANT_I;
                end
            end
            SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = GRANT_D;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port follows the granted cache; read data is broadcast and qualified by resp
    always_comb begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = ADDR_WIDTH'(0);
        bus.pmem_wdata   = LINE_WIDTH'(0);
        bus.i_pmem_resp  = 1'b0;
        bus.d_pmem_resp  = 1'b0;
        bus.i_pmem_rdata = bus.pmem_rdata;
        bus.d_pmem_rdata = bus.pmem_rdata;
        case (state)
            SERVE_I: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = bus.i_pmem_address;
                bus.pmem_wdata   = bus.d_pmem_wdata;
                bus.i_pmem_resp  = bus.pmem_resp;
            end
            SERVE_D: begin
                bus.pmem_write   = bus.d_pmem_write;
                bus.pmem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
                bus.pmem_address = bus.d_pmem_address;
                bus.pmem_wdata   = bus.d_pmem_wdata;
                bus.d_pmem_resp  = bus.pmem_resp;
            end
            default: ;
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    // A waiting cycle is one where a cache requests and neither owns nor is being granted the port
    logic i_wait;
    logic d_wait;

    assign i_wait = i_req && (state != SERVE_I) && (state_next != SERVE_I);
    assign d_wait = d_req && (state != SERVE_D) && (state_next != SERVE_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_grants        <= 16'd0;
            perf_d_grants        <= 16'd0;
            perf_conflict_cycles <= 16'd0;
        end else begin
            if ((state == SERVE_I) && bus.pmem_resp) begin
                perf_i_grants <= perf_i_grants + 16'd1;
            end
            if ((state == SERVE_D) && bus.pmem_resp) begin
                perf_d_grants <= perf_d_grants + 16'd1;
            end
            if (i_wait || d_wait) begin
                perf_conflict_cycles <= perf_conflict_cycles + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized cache/memory traffic
// compared every cycle against a transaction-level ownership model.
module tb_cache_mem_arbiter;
    logic clk;
    logic rst;

    cache_mem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_i_grants;
    logic [15:0] perf_d_grants;
    logic [15:0] perf_conflict_cycles;
`endif

    cache_mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: who owns the memory port (0 none, 1 I, 2 D), who wins the next tie, completion log
    int m_owner = 0;
    bit m_favour_d = 1'b1;
    int m_conflict = 0;
    int served[$];

    // Snapshot of DUT outputs at the last negedge
    logic         s_read, s_write, s_i_resp, s_d_resp;
    logic [15:0]  s_addr;
    logic [127:0] s_wdata, s_i_rdata;

    int mem_cnt = 0;
    int mem_lat = 3;
    bit mem_auto = 1'b1;
    bit pattern_en = 1'b0;
    logic [127:0] pattern = '0;
    bit i_auto = 1'b0, d_auto = 1'b0, rand_mode = 1'b0;
    int i_pulses = 0, d_pulses = 0, exp_i = 0, exp_d = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin : model
        int  nxt;
        bit  ireq, dreq;
        ireq = bus.i_pmem_read;
        dreq = bus.d_pmem_read || bus.d_pmem_write;
        if (rst) begin
            m_owner    = 0;
            m_favour_d = 1'b1;
            m_conflict = 0;
        end else begin
            case (m_owner)
                0: begin
                    nxt = 0;
                    if (ireq && dreq) nxt = m_favour_d ? 2 : 1;
                    else if (ireq)    nxt = 1;
                    else if (dreq)    nxt = 2;
                    if ((ireq && nxt != 1) || (dreq && nxt != 2)) m_conflict++;
                    m_owner = nxt;
                end
                1: begin
                    if (dreq) m_conflict++;
                    if (bus.pmem_resp) begin
                        served.push_back(1);
                        m_owner    = 0;
                        m_favour_d = 1'b1;
                    end
                end
                default: begin
                    if (ireq) m_conflict++;
                    if (bus.pmem_resp) begin
                        served.push_back(2);
                        m_owner    = 0;
                        m_favour_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic         e_read, e_write, e_ir, e_dr;
        logic [15:0]  e_addr;
        logic [127:0] e_wdata;
        if (check_en) begin
            e_read = 1'b0; e_write = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
            e_addr = '0;   e_wdata = '0;
            if (m_owner == 1) begin
                e_read  = 1'b1;
                e_addr  = bus.i_pmem_address;
                e_wdata = bus.d_pmem_wdata;
                e_ir    = bus.pmem_resp;
            end else if (m_owner == 2) begin
                e_write = bus.d_pmem_write;
                e_read  = bus.d_pmem_read && !bus.d_pmem_write;
                e_addr  = bus.d_pmem_address;
                e_wdata = bus.d_pmem_wdata;
                e_dr    = bus.pmem_resp;
            end
            check("pmem_read",    128'(bus.pmem_read),    128'(e_read));
            check("pmem_write",   128'(bus.pmem_write),   128'(e_write));
            check("pmem_address", 128'(bus.pmem_address), 128'(e_addr));
            check("pmem_wdata",   bus.pmem_wdata,         e_wdata);
            check("i_pmem_resp",  128'(bus.i_pmem_resp),  128'(e_ir));
            check("d_pmem_resp",  128'(bus.d_pmem_resp),  128'(e_dr));
            check("i_pmem_rdata", bus.i_pmem_rdata,       bus.pmem_rdata);
            check("d_pmem_rdata", bus.d_pmem_rdata,       bus.pmem_rdata);
        end
    end

    task automatic rand_step();
        bit wr;
        if (!bus.i_pmem_read && !s_i_resp && $urandom_range(0, 3) == 0) begin
            bus.i_pmem_address = 16'($urandom) & 16'hFFF0;
            bus.i_pmem_read    = 1'b1;
            exp_i++;
        end else if (bus.i_pmem_read && m_owner == 2 && $urandom_range(0, 15) == 0) begin
            bus.i_pmem_read = 1'b0;
            exp_i--;
        end
        if (!bus.d_pmem_read && !bus.d_pmem_write && !s_d_resp && $urandom_range(0, 3) == 0) begin
            wr = 1'($urandom_range(0, 1));
            bus.d_pmem_address = 16'($urandom) & 16'hFFF0;
            bus.d_pmem_wdata   = rand_line();
            bus.d_pmem_write   = wr;
            bus.d_pmem_read    = !wr;
            exp_d++;
        end else if ((bus.d_pmem_read || bus.d_pmem_write) && m_owner == 1 && $urandom_range(0, 15) == 0) begin
            bus.d_pmem_read  = 1'b0;
            bus.d_pmem_write = 1'b0;
            exp_d--;
        end
    endtask

    // One clock: snapshot outputs, then let caches retire/re-request and memory respond
    task automatic tick();
        @(negedge clk);
        s_read    = bus.pmem_read;
        s_write   = bus.pmem_write;
        s_addr    = bus.pmem_address;
        s_wdata   = bus.pmem_wdata;
        s_i_resp  = bus.i_pmem_resp;
        s_d_resp  = bus.d_pmem_resp;
        s_i_rdata = bus.i_pmem_rdata;
        @(posedge clk);
        #1;
        if (s_i_resp) begin
            bus.i_pmem_read = 1'b0;
            i_pulses++;
        end
        if (s_d_resp) begin
            bus.d_pmem_read  = 1'b0;
            bus.d_pmem_write = 1'b0;
            d_pulses++;
        end
        if (rst) mem_cnt = 0;
        if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            mem_cnt = 0;
            if (rand_mode) mem_lat = $urandom_range(2, 6);
        end else if ((s_read || s_write) && mem_auto && !rst) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat - 1) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = pattern_en ? pattern : rand_line();
            end
        end
        if (!bus.pmem_resp) bus.pmem_rdata = rand_line();
        if (i_auto && !bus.i_pmem_read && !s_i_resp) bus.i_pmem_read = 1'b1;
        if (d_auto && !bus.d_pmem_read && !s_d_resp) bus.d_pmem_read = 1'b1;
        if (rand_mode) rand_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_auto = 1'b0;
        d_auto = 1'b0;
        bus.i_pmem_read  = 1'b0;
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
        bus.pmem_resp    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_resp(input bit want_d, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = want_d ? s_d_resp : s_i_resp;
        end
        check(name, 128'(seen), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit drained;
        rst = 1'b1;
        bus.i_pmem_read = 1'b0;  bus.i_pmem_address = '0;
        bus.d_pmem_read = 1'b0;  bus.d_pmem_write = 1'b0;
        bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
        bus.pmem_rdata = '0;     bus.pmem_resp = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        tick();
        check("rst_pmem_read",    128'(s_read),   128'(0));
        check("rst_pmem_write",   128'(s_write),  128'(0));
        check("rst_pmem_address", 128'(s_addr),   128'(0));
        check("rst_pmem_wdata",   s_wdata,        128'(0));
        check("rst_i_resp",       128'(s_i_resp), 128'(0));
        check("rst_d_resp",       128'(s_d_resp), 128'(0));
`ifdef ARB_PERF_CNT_EN
        check("rst_perf_i", 128'(perf_i_grants), 128'(0));
`endif
        rst = 1'b0;

        // I-only fill at 0x0040, three-cycle memory
        i_pulses = 0; d_pulses = 0; served.delete();
        pattern = {16{8'hA5}}; pattern_en = 1'b1; mem_lat = 3;
        bus.i_pmem_address = 16'h0040;
        bus.i_pmem_read = 1'b1;
        tick();
        check("t1_idle_no_strobe", 128'(s_read), 128'(0));
        tick();
        check("t1_strobe", 128'(s_read), 128'(1));
        check("t1_addr",   128'(s_addr), 128'(16'h0040));
        wait_resp(1'b0, "t1_i_resp_seen");
        check("t1_rdata",    s_i_rdata,        {16{8'hA5}});
        check("t1_i_pulses", 128'(i_pulses),   128'(1));
        check("t1_d_pulses", 128'(d_pulses),   128'(0));
        tick();
        check("t1_bubble", 128'(s_read), 128'(0));
        pattern_en = 1'b0;

        // D writeback at 0x1230
        i_pulses = 0; d_pulses = 0;
        bus.d_pmem_address = 16'h1230;
        bus.d_pmem_wdata   = 128'h0123456789ABCDEF0123456789ABCDEF;
        bus.d_pmem_write   = 1'b1;
        tick();
        tick();
        check("t2_write", 128'(s_write), 128'(1));
        check("t2_read",  128'(s_read),  128'(0));
        check("t2_addr",  128'(s_addr),  128'(16'h1230));
        check("t2_wdata", s_wdata,       128'h0123456789ABCDEF0123456789ABCDEF);
        wait_resp(1'b1, "t2_d_resp_seen");
        check("t2_d_pulses", 128'(d_pulses), 128'(1));
        check("t2_i_pulses", 128'(i_pulses), 128'(0));
        tick();

        // Simultaneous requests right after reset: D first, bubble, then I
        do_reset();
        served.delete();
        bus.i_pmem_address = 16'h0100; bus.i_pmem_read = 1'b1;
        bus.d_pmem_address = 16'h2000; bus.d_pmem_read = 1'b1;
        tick();
        tick();
        check("t3_d_first_read", 128'(s_read), 128'(1));
        check("t3_d_first_addr", 128'(s_addr), 128'(16'h2000));
        wait_resp(1'b1, "t3_d_resp_seen");
        tick();
        check("t3_bubble", 128'(s_read), 128'(0));
        tick();
        check("t3_i_read", 128'(s_read), 128'(1));
        check("t3_i_addr", 128'(s_addr), 128'(16'h0100));
        wait_resp(1'b0, "t3_i_resp_seen");
        check("t3_served_n", 128'(served.size()), 128'(2));
        check("t3_served_0", 128'(served[0]),      128'(2));
        check("t3_served_1", 128'(served[1]),      128'(1));
        tick();

        // Continuous contention: D, I, D, I with 13 waiting cycles at memory latency 3
        do_reset();
        served.delete();
        bus.i_pmem_address = 16'h0300;
        bus.d_pmem_address = 16'h4400;
        i_auto = 1'b1; d_auto = 1'b1;
        bus.i_pmem_read = 1'b1; bus.d_pmem_read = 1'b1;
        for (int k = 0; k < 80 && served.size() < 4; k++) tick();
        check("t4_served_n", 128'(served.size()), 128'(4));
        check("t4_served_0", 128'(served[0]), 128'(2));
        check("t4_served_1", 128'(served[1]), 128'(1));
        check("t4_served_2", 128'(served[2]), 128'(2));
        check("t4_served_3", 128'(served[3]), 128'(1));
        check("t4_model_wait", 128'(m_conflict), 128'(13));
`ifdef ARB_PERF_CNT_EN
        check("t4_perf_i",        128'(perf_i_grants),        128'(2));
        check("t4_perf_d",        128'(perf_d_grants),        128'(2));
        check("t4_perf_conflict", 128'(perf_conflict_cycles), 128'(16'(m_conflict)));
`endif
        do_reset();
`ifdef ARB_PERF_CNT_EN
        check("t4_perf_i_rst",        128'(perf_i_grants),        128'(0));
        check("t4_perf_d_rst",        128'(perf_d_grants),        128'(0));
        check("t4_perf_conflict_rst", 128'(perf_conflict_cycles), 128'(0));
`endif

        // Reset during a busy D writeback, then a late memory resp in IDLE
        served.delete();
        mem_auto = 1'b0;
        bus.d_pmem_address = 16'h3450;
        bus.d_pmem_wdata   = rand_line();
        bus.d_pmem_write   = 1'b1;
        tick();
        tick();
        check("t5_write_busy", 128'(s_write), 128'(1));
        do_reset();
        bus.pmem_resp = 1'b1;
        tick();
        check("t5_write_after_rst", 128'(s_write),  128'(0));
        check("t5_read_after_rst",  128'(s_read),   128'(0));
        check("t5_late_d_resp",     128'(s_d_resp), 128'(0));
        check("t5_late_i_resp",     128'(s_i_resp), 128'(0));
        check("t5_served_n",        128'(served.size()), 128'(0));
        mem_auto = 1'b1;

        // Randomized traffic with variable memory latency and occasional withdrawn requests
        do_reset();
        i_pulses = 0; d_pulses = 0; exp_i = 0; exp_d = 0;
        rand_mode = 1'b1;
        repeat (2000) tick();
        rand_mode = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 300 && !drained; k++) begin
            tick();
            drained = !bus.i_pmem_read && !bus.d_pmem_read && !bus.d_pmem_write;
        end
        check("rand_drained",  128'(drained),  128'(1));
        check("rand_i_served", 128'(i_pulses), 128'(exp_i));
        check("rand_d_served", 128'(d_pulses), 128'(exp_d));
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
